// File: rtl/sorted_stream_out_if.sv
// Element stream from sorted_stream_out to a serial consumer: one element per
// valid/ready transfer, tagged with its rank and a last-element flag.
interface sorted_stream_out_if #(
  parameter int WIDTH = 3,
  parameter int IDXW  = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;

  modport master (
    output out_valid, out_data, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/sorted_stream_out.sv
// Captures the merged sorted vector in one cycle and streams it out one element
// per valid/ready transfer, ascending or descending, with rank and last flag.
module sorted_stream_out #(
  parameter int WIDTH = 3,
  parameter int n     = 8,
  parameter int IDXW  = $clog2(2*n)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   desc_i,
  input  logic [2*n*WIDTH-1:0]   c_in_i,
  output logic                   busy_o,
  output logic                   done_o,
  sorted_stream_out_if.master    out_if
);
  localparam int N2 = 2 * n;
  localparam logic [IDXW-1:0] LAST = IDXW'(N2 - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shadow_q [N2];
  logic [WIDTH-1:0] shadow_d [N2];
  logic             desc_q, desc_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    desc_d   = desc_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          for (int unsigned k = 0; k < N2; k++) begin
            shadow_d[k] = c_in_i[k*WIDTH +: WIDTH];
          end
          desc_d  = desc_i;
          ptr_d   = desc_i ? LAST : '0;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_if.out_ready) begin
          // The pointer may step past either end on the final transfer; it is
          // never read again before the next capture reloads it.
          ptr_d = desc_q ? ptr_q - IDXW'(1) : ptr_q + IDXW'(1);
          cnt_d = cnt_q + IDXW'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      for (int unsigned k = 0; k < N2; k++) begin
        shadow_q[k] <= '0;
      end
      desc_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      desc_q   <= desc_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode registered state only; no path from c_in_i/start_i/desc_i.
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign out_if.out_valid = (state_q == SEND);
  assign out_if.out_last  = (state_q == SEND) && (cnt_q == LAST);
  assign out_if.out_data  = shadow_q[ptr_q];
  assign out_if.out_idx   = ptr_q;
endmodule

// File: tb/tb_sorted_stream_out.sv
// Randomized self-checking bench for sorted_stream_out against a queue-based
// model of the expected element order.
module tb_sorted_stream_out;
  localparam int WIDTH = 3;
  localparam int N     = 8;
  localparam int IDXW  = 4;
  localparam int NE    = 2 * N;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic                  desc;
  logic [NE*WIDTH-1:0]   c_in;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;

  sorted_stream_out_if #(.WIDTH(WIDTH), .IDXW(IDXW)) sif ();

  sorted_stream_out #(.WIDTH(WIDTH), .n(N), .IDXW(IDXW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .desc_i  (desc),
    .c_in_i  (c_in),
    .busy_o  (busy),
    .done_o  (done),
    .out_if  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NE*WIDTH-1:0] rand_sorted();
    int q[$];
    logic [NE*WIDTH-1:0] v;
    for (int i = 0; i < NE; i++) q.push_back(int'($urandom_range(0, 7)));
    q.sort();
    v = '0;
    for (int i = 0; i < NE; i++) v[i*WIDTH +: WIDTH] = WIDTH'(q[i]);
    return v;
  endfunction

  function automatic logic [NE*WIDTH-1:0] rand_any();
    logic [NE*WIDTH-1:0] v;
    v = {$urandom, $urandom};
    return v;
  endfunction

  // mode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
  // abort_after >= 0 resets the DUT once that many transfers have completed.
  task automatic run_burst(input logic [NE*WIDTH-1:0] vec, input logic d,
                           input int mode, input int abort_after, input bit poke);
    int exp_idx[$];
    int exp_dat[$];
    int xfers;
    int cyc;
    logic rdy;
    for (int t = 0; t < NE; t++) begin
      int i;
      i = d ? NE - 1 - t : t;
      exp_idx.push_back(i);
      exp_dat.push_back(int'(vec[i*WIDTH +: WIDTH]));
    end
    start = 1'b1;
    desc  = d;
    c_in  = vec;
    @(negedge clk);
    start = 1'b0;
    desc  = ~d;
    c_in  = ~vec;
    xfers = 0;
    cyc   = 0;
    while (xfers < NE && cyc < 400) begin
      if (xfers == abort_after) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_valid", int'(sif.out_valid), 0);
        chk("abort_busy",  int'(busy), 0);
        chk("abort_done",  int'(done), 0);
        chk("abort_last",  int'(sif.out_last), 0);
        chk("abort_data",  int'(sif.out_data), 0);
        chk("abort_idx",   int'(sif.out_idx), 0);
        return;
      end
      chk("valid", int'(sif.out_valid), 1);
      chk("busy",  int'(busy), 1);
      chk("done",  int'(done), 0);
      chk("data",  int'(sif.out_data), exp_dat[xfers]);
      chk("idx",   int'(sif.out_idx), exp_idx[xfers]);
      chk("last",  int'(sif.out_last), (xfers == NE - 1) ? 1 : 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sif.out_ready = rdy;
      start = poke && ($urandom_range(0, 1) == 1);
      if (start) c_in = rand_any();
      @(negedge clk);
      if (rdy) xfers++;
      cyc++;
    end
    chk("xfers", xfers, NE);
    chk("done_pulse", int'(done), 1);
    chk("done_valid", int'(sif.out_valid), 0);
    chk("done_last",  int'(sif.out_last), 0);
    chk("done_busy",  int'(busy), 1);
    start = poke;
    c_in  = rand_any();
    sif.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    chk("idle_done",  int'(done), 0);
    chk("idle_busy",  int'(busy), 0);
    chk("idle_valid", int'(sif.out_valid), 0);
  endtask

  initial begin
    logic [NE*WIDTH-1:0] ramp;
    ramp = '0;
    for (int k = 0; k < NE; k++) ramp[k*WIDTH +: WIDTH] = WIDTH'(k / 2);

    rst = 1'b0;
    start = 1'b1;
    desc = 1'b0;
    c_in = rand_any();
    sif.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy",  int'(busy), 0);
      chk("rst_valid", int'(sif.out_valid), 0);
      chk("rst_done",  int'(done), 0);
      chk("rst_data",  int'(sif.out_data), 0);
      chk("rst_idx",   int'(sif.out_idx), 0);
    end
    rst = 1'b1;
    start = 1'b0;

    run_burst(ramp, 1'b0, 0, -1, 1'b0);
    run_burst(ramp, 1'b1, 0, -1, 1'b0);
    run_burst(ramp, 1'b0, 1, -1, 1'b0);
    run_burst(ramp, 1'b1, 1, -1, 1'b1);
    run_burst(rand_sorted(), 1'b0, 2, -1, 1'b1);
    run_burst(ramp, 1'b0, 0, 5, 1'b0);
    run_burst(ramp, 1'b0, 0, -1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      run_burst(rand_sorted(), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), -1, 1'b1);
    end
    run_burst(rand_sorted(), 1'b1, 2, 11, 1'b1);
    run_burst(rand_sorted(), 1'b1, 2, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
